// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-subset sequencer.
//   - opcode / funct encodings of the executed instruction subset
//   - sequencer state enum (also exported on the debug port)
//   - sext16: 16-bit immediate sign extension
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SLLV   = 6'h04;
    localparam logic [5:0] F_ADD    = 6'h20;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_seq_ctrl_if.sv
// mips_seq_ctrl_if: instruction-ROM and data-memory bus of the sequencer.
//   imem_addr  (master->slave) ROM word address, registered
//   imem_rdata (slave->master) ROM word for imem_addr, valid the cycle after
//                              imem_addr changes
//   dmem_req   (master->slave) read request
//   dmem_addr  (master->slave) read byte address
//   dmem_rdata (slave->master) read data, meaningful only with dmem_ack
//   dmem_ack   (slave->master) one-cycle read completion
//
// Data-read handshake: the master raises dmem_req with dmem_addr and keeps
// both stable until it samples dmem_ack=1 on a clock edge; on that same edge
// it takes dmem_rdata and drops dmem_req (low from the next cycle). An ack
// seen while no request is outstanding is ignored. There is no timeout.
interface mips_seq_ctrl_if #(
    parameter int PC_W = 3
) ();
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_rdata;
    logic            dmem_ack;

    modport master (
        output imem_addr, dmem_req, dmem_addr,
        input  imem_rdata, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_addr, dmem_req, dmem_addr,
        output imem_rdata, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: REG_N x 32 register file.
//   clk, rst           clock, synchronous active-high reset (clears all)
//   raddr_a/rdata_a    asynchronous read port A
//   raddr_b/rdata_b    asynchronous read port B
//   we/waddr/wdata     synchronous write port
// Entry 0 is never written and always reads as zero.
module mips_regfile #(
    parameter int REG_N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(REG_N)-1:0] raddr_a,
    output logic [31:0]              rdata_a,
    input  logic [$clog2(REG_N)-1:0] raddr_b,
    output logic [31:0]              rdata_b,
    input  logic                     we,
    input  logic [$clog2(REG_N)-1:0] waddr,
    input  logic [31:0]              wdata
);
    logic [31:0] regs [REG_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/mips_seq_ctrl.sv
// mips_seq_ctrl: multi-cycle sequencer executing a MIPS subset
// (add, sllv, srl, addi, lw, j) out of a small instruction ROM.
//   clk, rst   clock, synchronous active-high reset
//   bus        instruction ROM + data-memory read bus (master side)
//   dbg_sel    register index shown on led after halt (switch=0)
//   switch     led view: 0 = reg[dbg_sel][7:0], 1 = {illegal, retired[6:0]}
//   led        registered LED output, 0 until HALT
//   halted     high while in HALT
//   retired    instructions retired since reset, saturating at 255
//   dbg_state  current sequencer state
// Flow: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH, or HALT once
// MAX_INSTR instructions have retired. Register indices alias mod REG_N
// (REG_N must be a power of two).
module mips_seq_ctrl
    import mips_pkg::*;
#(
    parameter int PC_W      = 3,
    parameter int MAX_INSTR = 8,
    parameter int REG_N     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_seq_ctrl_if.master        bus,
    input  logic [2:0]             dbg_sel,
    input  logic                   switch,
    output logic [7:0]             led,
    output logic                   halted,
    output logic [7:0]             retired,
    output state_t                 dbg_state
);
    localparam int         IDX_W   = $clog2(REG_N);
    localparam logic [8:0] MAX_CNT = 9'(MAX_INSTR);

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   next_pc;
    logic [31:0]       ir;
    logic [31:0]       res;
    logic [IDX_W-1:0]  dest;
    logic              wr_pend;
    logic              illegal;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [IDX_W-1:0]  idx_rs;
    logic [IDX_W-1:0]  idx_rt;
    logic [IDX_W-1:0]  idx_rd;
    logic [IDX_W-1:0]  dbg_idx;
    logic [IDX_W-1:0]  ra_a;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic              rf_we;
    logic [8:0]        retired_plus;
    logic              unused_ir_bits;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign shamt   = ir[10:6];
    assign imm     = ir[15:0];
    // Low bits of each 5-bit field select the implemented register (mod REG_N).
    assign idx_rs  = ir[21 +: IDX_W];
    assign idx_rt  = ir[16 +: IDX_W];
    assign idx_rd  = ir[11 +: IDX_W];
    assign dbg_idx = IDX_W'(dbg_sel);
    assign unused_ir_bits = ^{ir[25:21+IDX_W], ir[20:16+IDX_W]};

    // In HALT the rs port is borrowed for the LED register view; nothing else
    // reads the register file there.
    assign ra_a  = (state == S_HALT) ? dbg_idx : idx_rs;
    assign rf_we = (state == S_WB) && wr_pend;

    assign retired_plus = {1'b0, retired} + 9'd1;
    assign dbg_state    = state;

    mips_regfile #(.REG_N(REG_N)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ra_a),
        .rdata_a (rs_val),
        .raddr_b (idx_rt),
        .rdata_b (rt_val),
        .we      (rf_we),
        .waddr   (dest),
        .wdata   (res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            pc            <= '0;
            next_pc       <= '0;
            ir            <= '0;
            res           <= '0;
            dest          <= '0;
            wr_pend       <= 1'b0;
            illegal       <= 1'b0;
            retired       <= '0;
            led           <= '0;
            halted        <= 1'b0;
            bus.imem_addr <= '0;
            bus.dmem_req  <= 1'b0;
            bus.dmem_addr <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    bus.imem_addr <= pc;
                    state         <= S_DECODE;
                end
                S_DECODE: begin
                    ir    <= bus.imem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    next_pc <= pc + PC_W'(1);
                    wr_pend <= 1'b0;
                    state   <= S_WB;
                    case (opcode)
                        OP_RTYPE: begin
                            dest <= idx_rd;
                            case (funct)
                                F_ADD: begin
                                    res     <= rs_val + rt_val;
                                    wr_pend <= 1'b1;
                                end
                                F_SLLV: begin
                                    res     <= rt_val << rs_val[4:0];
                                    wr_pend <= 1'b1;
                                end
                                F_SRL: begin
                                    res     <= rt_val >> shamt;
                                    wr_pend <= 1'b1;
                                end
                                default: illegal <= 1'b1;
                            endcase
                        end
                        OP_ADDI: begin
                            res     <= rs_val + sext16(imm);
                            dest    <= idx_rt;
                            wr_pend <= 1'b1;
                        end
                        OP_LW: begin
                            bus.dmem_addr <= rs_val + sext16(imm);
                            bus.dmem_req  <= 1'b1;
                            dest          <= idx_rt;
                            state         <= S_MEM;
                        end
                        OP_J: begin
                            next_pc <= ir[PC_W-1:0];
                        end
                        default: illegal <= 1'b1;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        res          <= bus.dmem_rdata;
                        wr_pend      <= 1'b1;
                        bus.dmem_req <= 1'b0;
                        state        <= S_WB;
                    end
                end
                S_WB: begin
                    pc <= next_pc;
                    if (retired != 8'hFF) begin
                        retired <= retired + 8'd1;
                    end
                    if (retired_plus == MAX_CNT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    led <= switch ? {illegal, retired[6:0]} : rs_val[7:0];
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_seq_ctrl.sv
module tb_mips_seq_ctrl;
    import mips_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- DUT ----------------
    mips_seq_ctrl_if #(.PC_W(3)) bus ();
    logic [2:0] dbg_sel = 3'd0;
    logic       switch  = 1'b0;
    logic [7:0] led;
    logic       halted;
    logic [7:0] retired;
    state_t     dbg_state;

    logic [31:0] rom [8];
    assign bus.imem_rdata = rom[bus.imem_addr];

    mips_seq_ctrl #(.PC_W(3), .MAX_INSTR(8), .REG_N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_sel   (dbg_sel),
        .switch    (switch),
        .led       (led),
        .halted    (halted),
        .retired   (retired),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observations collected while a program runs
    int          halt_cyc;
    int          req_cnt;
    logic [31:0] lw_addr;
    logic        addr_moved;
    logic        req_after_ack;
    logic        led_nz;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0BAD_F00D;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_req"},     {31'd0, bus.dmem_req}, 32'd0);
        check({pfx, "_daddr"},   bus.dmem_addr, 32'd0);
        check({pfx, "_iaddr"},   {29'd0, bus.imem_addr}, 32'd0);
        check({pfx, "_led"},     {24'd0, led}, 32'd0);
        check({pfx, "_halted"},  {31'd0, halted}, 32'd0);
        check({pfx, "_retired"}, {24'd0, retired}, 32'd0);
        check({pfx, "_state"},   32'(dbg_state), 32'(S_FETCH));
    endtask

    // Runs from reset release until halted, serving lw with an ack placed on
    // the ack_wait-th cycle that dmem_req is seen high.
    task automatic run_prog(input int ack_wait, input logic [31:0] rd);
        logic ack_prev;
        ack_prev      = 1'b0;
        halt_cyc      = -1;
        req_cnt       = 0;
        lw_addr       = 32'hFFFF_FFFF;
        addr_moved    = 1'b0;
        req_after_ack = 1'b1;
        led_nz        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack_prev) begin
                req_after_ack = bus.dmem_req;
                ack_prev      = 1'b0;
            end
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = 32'h0BAD_F00D;
            if (halted) begin
                halt_cyc = cyc;
                break;
            end
            if (led != 8'd0) led_nz = 1'b1;
            if (bus.dmem_req) begin
                req_cnt++;
                if (req_cnt == 1) lw_addr = bus.dmem_addr;
                else if (bus.dmem_addr != lw_addr) addr_moved = 1'b1;
                if (req_cnt == ack_wait) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rd;
                    ack_prev       = 1'b1;
                end
            end
        end
        check("halted", {31'd0, halted}, 32'd1);
    endtask

    task automatic view(input string tag, input logic [2:0] sel, input logic sw, input logic [7:0] exp);
        dbg_sel = sel;
        switch  = sw;
        repeat (2) @(negedge clk);
        check(tag, {24'd0, led}, {24'd0, exp});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Program A: arithmetic, shifts, lw, j
        rom[0] = 32'h2004_3456; // addi $4,$0,0x3456
        rom[1] = 32'h2005_FFFF; // addi $5,$0,0xffff
        rom[2] = 32'h00A4_3020; // add  $6,$5,$4     -> 0x00003455
        rom[3] = 32'h2003_0007; // addi $3,$0,7
        rom[4] = 32'h00C3_3004; // sllv $6,$3,$6     -> 7<<21 = 0x00E00000
        rom[5] = 32'h0003_1842; // srl  $3,$3,1      -> 3
        rom[6] = 32'h8C85_9ABC; // lw   $5,0x9abc($4)
        rom[7] = 32'h0812_3456; // j    0x123456
        do_reset();
        check_reset_state("rst");
        rst = 1'b0;
        run_prog(3, 32'hA5A5_A5A5);
        check("a_lw_addr",    lw_addr, 32'hFFFF_CF12);
        check("a_req_cycles", req_cnt, 32'd3);
        check("a_addr_moved", {31'd0, addr_moved}, 32'd0);
        check("a_req_drop",   {31'd0, req_after_ack}, 32'd0);
        check("a_led_prehalt", {31'd0, led_nz}, 32'd0);
        check("a_halt_cycle", halt_cyc, 32'd35);   // 7 x 4 + (4 + 3)
        check("a_retired",    {24'd0, retired}, 32'd8);
        view("a_r4", 3'd4, 1'b0, 8'h56);
        view("a_r3", 3'd3, 1'b0, 8'h03);
        view("a_r5", 3'd5, 1'b0, 8'hA5);
        view("a_r6", 3'd6, 1'b0, 8'h00);
        view("a_stat", 3'd0, 1'b1, 8'h08);
        repeat (10) @(negedge clk);
        check("a_absorb_state", 32'(dbg_state), 32'(S_HALT));
        check("a_absorb_ret",   {24'd0, retired}, 32'd8);
        check("a_absorb_pc",    {29'd0, bus.imem_addr}, 32'd7);

        // Program B: illegal words, $0 write, alias, loop back via j
        rom[0] = 32'hFC00_0000; // illegal opcode
        rom[1] = 32'h2000_0005; // addi $0,$0,5 (discarded)
        rom[2] = 32'h2002_FFFE; // addi $2,$0,-2
        rom[3] = 32'h0002_0902; // srl  $1,$2,4      -> 0x0FFFFFFF
        rom[4] = 32'h0000_003F; // R-type, unknown funct
        rom[5] = 32'h21E7_0001; // addi $7,$15,1     ($15 aliases $7) -> 1
        rom[6] = 32'h0800_0000; // j 0
        rom[7] = 32'h0000_0000;
        do_reset();
        rst = 1'b0;
        run_prog(1, 32'h0);
        check("b_halt_cycle", halt_cyc, 32'd32);
        check("b_no_req",     req_cnt, 32'd0);
        view("b_r0", 3'd0, 1'b0, 8'h00);
        view("b_r2", 3'd2, 1'b0, 8'hFE);
        view("b_r1", 3'd1, 1'b0, 8'hFF);
        view("b_r7", 3'd7, 1'b0, 8'h01);
        view("b_stat", 3'd0, 1'b1, 8'h88);

        // Reset in MEM, then stray ack, then Program C
        rom[0] = 32'h2004_3456;
        rom[1] = 32'h2005_FFFF;
        rom[2] = 32'h00A4_3020;
        rom[3] = 32'h2003_0007;
        rom[4] = 32'h00C3_3004;
        rom[5] = 32'h0003_1842;
        rom[6] = 32'h8C85_9ABC;
        rom[7] = 32'h0812_3456;
        do_reset();
        switch = 1'b0;
        rst = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.dmem_req) begin
                req_cnt = 1;
                break;
            end
        end
        check("d_req_seen", req_cnt, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("d_rst");
        rom[0] = 32'h8C82_0010; // lw   $2,0x10($4)  ($4 must be 0 again)
        for (int i = 1; i < 8; i++) rom[i] = 32'h2084_0001; // addi $4,$4,1
        @(negedge clk);
        rst = 1'b0;
        bus.dmem_ack   = 1'b1;             // stray ack with no request pending
        bus.dmem_rdata = 32'hDEAD_BEEF;
        run_prog(1, 32'h0000_005A);
        check("c_lw_addr",    lw_addr, 32'h0000_0010);
        check("c_req_cycles", req_cnt, 32'd1);
        check("c_req_drop",   {31'd0, req_after_ack}, 32'd0);
        check("c_halt_cycle", halt_cyc, 32'd33);   // (4 + 1) + 7 x 4
        view("c_r4", 3'd4, 1'b0, 8'h07);
        view("c_r2", 3'd2, 1'b0, 8'h5A);
        view("c_stat", 3'd0, 1'b1, 8'h08);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
